mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL take parameter WAIT_CYCLES, default 4: number of cycles the memory-side strobes are held per access; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports MEM_r_en and MEM_w_en, inputs, 1 bit each: pipeline MEM-stage read and write requests.
REQ-005 The block SHALL have ports address and data_in, inputs, 32 bits each: the pipeline byte address and the store data.
REQ-006 The block SHALL have port data_out, output, 32 bits: registered load result returned to the pipeline.
REQ-007 The block SHALL have ports freeze and ready, outputs, 1 bit each: freeze stalls the pipeline; ready is a one-cycle completion pulse.
REQ-008 The block SHALL have port fault, output, 1 bit: out-of-range or misaligned access flag.
REQ-009 The block SHALL have ports mem_r_en and mem_w_en (outputs, 1 bit each), mem_address and mem_data_in (outputs, 32 bits each), and mem_data_out (input, 32 bits): the downstream data-memory side.

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-011 In IDLE, when MEM_r_en or MEM_w_en is high, the block SHALL latch address, data_in and the operation, and move to ACCESS; freeze SHALL be high combinationally in that same cycle.
REQ-012 If MEM_r_en and MEM_w_en are both high, the block SHALL perform a write only and SHALL leave data_out unchanged.
REQ-013 ACCESS SHALL last exactly WAIT_CYCLES cycles, timed by a down-counter loaded with WAIT_CYCLES-1; when the counter reaches 0, the FSM SHALL go to DONE.
REQ-014 mem_address and mem_data_in SHALL carry the latched values unmodified during ACCESS and SHALL be 0 otherwise; the downstream memory performs base-offset removal.
REQ-015 On a read, mem_r_en SHALL be high in every ACCESS cycle, and data_out SHALL capture mem_data_out at the edge that leaves the last ACCESS cycle.
REQ-016 On a write, mem_w_en SHALL be high only in the last ACCESS cycle, so exactly one write occurs per request.
REQ-017 freeze SHALL be high in the request cycle and in all ACCESS cycles; in DONE, freeze SHALL be 0 and ready SHALL be 1; DONE SHALL always return to IDLE.
REQ-018 With a request seen in cycle T, ready SHALL be high in cycle T+WAIT_CYCLES+1; the earliest next request is accepted in cycle T+WAIT_CYCLES+2.
REQ-019 Changes to request inputs during ACCESS or DONE SHALL be ignored, and the latched access SHALL complete.
REQ-020 data_out SHALL hold its value until the next read completes.

Reset
REQ-021 While rst is high, the FSM SHALL go to IDLE and the counter, data_out, the latched registers, ready, fault, mem_r_en and mem_w_en SHALL all be 0.
REQ-022 A reset asserted during ACCESS SHALL abort the access with no mem_w_en pulse in or after the reset cycle, and freeze SHALL be 0 in the cycle after reset deasserts.

Configuration
REQ-023 With macro MEM_ADDR_CHECK_EN defined, a request is faulting when address < 1024, address >= 1280, or address[1:0] != 0.
REQ-024 With MEM_ADDR_CHECK_EN defined, a faulting request SHALL go IDLE->DONE directly, skip ACCESS with no memory strobes, assert fault with ready in DONE, and, for a read, set data_out to 0.
REQ-025 Without MEM_ADDR_CHECK_EN, the fault port SHALL still exist and be tied to 0, and every request SHALL follow the normal path.

Structure
REQ-026 Shared package arm_mem_pkg SHALL hold the FSM state typedef, MEMORY_START_POSITION = 1024 and MEMORY_WORDS = 64; the data memory also uses these constants.
REQ-027 The wait counter SHALL be sub-module mem_wait_counter, with load, decrement and zero flag, and width $clog2(WAIT_CYCLES+1).

Verification (WAIT_CYCLES=4)
REQ-028 Scenario: write 0xDEADBEEF to 1028 -> freeze high for 5 cycles, one mem_w_en pulse with mem_address=1028, ready in cycle 6, data_out unchanged.
REQ-029 Scenario: read 1028 with memory returning 0xDEADBEEF -> mem_r_en high for 4 cycles, ready in cycle 6, data_out=0xDEADBEEF held afterwards.
REQ-030 Scenario: MEM_r_en and MEM_w_en both high to 1032 with data 0x5 -> write only, data_out keeps its prior value.
REQ-031 Scenario: rst pulsed in the 2nd ACCESS cycle of a write -> no mem_w_en pulse ever, all outputs 0, and the next read completes normally.
REQ-032 Scenario: with MEM_ADDR_CHECK_EN, read 1282 -> no mem strobes, ready and fault high in cycle 2, data_out=0; without the macro -> normal 6-cycle access, fault=0.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory access path: controller FSM states,
// data-memory placement and the address legality helper.
package arm_mem_pkg;

    localparam int MEMORY_START_POSITION = 1024;
    localparam int MEMORY_WORDS          = 64;

    // First byte address past the end of the data memory window.
    localparam logic [31:0] MEMORY_END_POSITION =
        32'(MEMORY_START_POSITION + MEMORY_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // True when a byte address falls outside the data memory window or is not
    // word aligned.
    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr < 32'(MEMORY_START_POSITION)) ||
               (addr >= MEMORY_END_POSITION) ||
               (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the memory wait states: loadable, decrements by one
// on request and flags when it has reached zero.
module mem_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load takes priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Pipeline MEM-stage to data-memory access controller.
// Latches a read or write request, holds the memory strobes for WAIT_CYCLES
// cycles while freezing the pipeline, then pulses ready for one cycle.
// Optional build macro MEM_ADDR_CHECK_EN: out-of-range or misaligned requests
// skip the memory access and complete immediately with fault asserted.
module mem_access_ctrl
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_r_en,
    input  logic        MEM_w_en,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        freeze,
    output logic        ready,
    output logic        fault,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    mem_state_t  state;
    mem_state_t  next_state;

    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_read;
    logic        lat_write;

    logic        request;
    logic        req_fault;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    assign request = MEM_r_en | MEM_w_en;

`ifdef MEM_ADDR_CHECK_EN
    logic lat_fault;
    assign req_fault = addr_fault(address);
`else
    assign req_fault = 1'b0;
`endif

    mem_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(CNT_W'(WAIT_CYCLES - 1)),
        .dec       (cnt_dec),
        .zero      (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the request when it is accepted; a simultaneous read and write
    // is treated as a write only.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
        end else if ((state == IDLE) && request) begin
            lat_addr  <= address;
            lat_data  <= data_in;
            lat_read  <= MEM_r_en & ~MEM_w_en;
            lat_write <= MEM_w_en;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    // Remember whether the accepted request was illegal so DONE can flag it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_fault <= 1'b0;
        end else if ((state == IDLE) && request) begin
            lat_fault <= req_fault;
        end
    end
`endif

    // Load result: captured on the edge leaving the last ACCESS cycle, cleared
    // by a faulting read, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if ((state == ACCESS) && cnt_zero && lat_read) begin
            data_out <= mem_data_out;
        end else if ((state == IDLE) && MEM_r_en && !MEM_w_en && req_fault) begin
            data_out <= '0;
        end
    end

    // Next-state logic and all handshake/memory-side outputs; reset forces the
    // outputs low so an aborted access never strobes the memory.
    always_comb begin
        next_state  = state;
        freeze      = 1'b0;
        ready       = 1'b0;
        fault       = 1'b0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state)
            IDLE: begin
                if (request) begin
                    freeze = 1'b1;
                    if (req_fault) begin
                        next_state = DONE;
                    end else begin
                        next_state = ACCESS;
                        cnt_load   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                freeze      = 1'b1;
                mem_address = lat_addr;
                mem_data_in = lat_data;
                mem_r_en    = lat_read;
                // A single write strobe in the final wait cycle.
                mem_w_en    = lat_write & cnt_zero;
                cnt_dec     = ~cnt_zero;
                if (cnt_zero) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
`ifdef MEM_ADDR_CHECK_EN
                fault      = lat_fault;
`endif
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (rst) begin
            freeze      = 1'b0;
            ready       = 1'b0;
            fault       = 1'b0;
            mem_r_en    = 1'b0;
            mem_w_en    = 1'b0;
            mem_address = '0;
            mem_data_in = '0;
            cnt_load    = 1'b0;
            cnt_dec     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl (WAIT_CYCLES=4) with a behavioural data memory.
// Expected outcomes are queued when a request is driven and checked when the
// DUT raises ready. Honours MEM_ADDR_CHECK_EN the same way as the design.
module tb_mem_access_ctrl;

    localparam int WAIT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_r_en;
    logic        MEM_w_en;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        freeze;
    logic        ready;
    logic        fault;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    mem_access_ctrl #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_r_en    (MEM_r_en),
        .MEM_w_en    (MEM_w_en),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .freeze      (freeze),
        .ready       (ready),
        .fault       (fault),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Downstream data memory: 64 words, indexed by address bits [7:2].
    logic [31:0] tb_mem [64];
    assign mem_data_out = tb_mem[mem_address[7:2]];
    always @(posedge clk) begin
        if (mem_w_en) tb_mem[mem_address[7:2]] <= mem_data_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        fault;
        int          wcount;
        int          rcount;
        int          fcycles;
        int          latency;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          t_req;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[12];

    logic sb_en = 1'b0;
    int   ready_cnt = 0;
    int   wpulses = 0;
    int   wcnt = 0;
    int   rcnt = 0;
    int   fcnt = 0;

    // Monitor: accumulates strobe/freeze activity and settles each transaction on ready.
    always @(negedge clk) begin
        if (mem_w_en) wpulses++;
        if (rst) begin
            wcnt = 0;
            rcnt = 0;
            fcnt = 0;
        end else if (sb_en) begin
            if (freeze) fcnt++;
            if (mem_w_en) begin
                wcnt++;
                if (sb_q.size() > 0) begin
                    chk("w_addr", mem_address, sb_q[0].addr);
                    chk("w_data", mem_data_in, sb_q[0].wdata);
                end
            end
            if (mem_r_en) begin
                rcnt++;
                if (sb_q.size() > 0) chk("r_addr", mem_address, sb_q[0].addr);
            end
            if (ready) begin
                ready_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("data_out", data_out, e.dout);
                    chk("fault", 32'(fault), 32'(e.fault));
                    chk("freeze_in_done", 32'(freeze), 32'd0);
                    chk("w_pulses", 32'(wcnt), 32'(e.wcount));
                    chk("r_cycles", 32'(rcnt), 32'(e.rcount));
                    chk("freeze_cycles", 32'(fcnt), 32'(e.fcycles));
                    chk("ready_latency", 32'(cyc - e.t_req), 32'(e.latency));
                end
                wcnt = 0;
                rcnt = 0;
                fcnt = 0;
            end
        end
    end

    // Drive one request (entered and left just after a rising edge), scribble
    // on the request inputs during the access, then wait for completion.
    task automatic do_req(input vec_t v);
        exp_t e;
        int   start;
        int   n;
        MEM_r_en  = v.rd;
        MEM_w_en  = v.wr;
        address   = v.addr;
        data_in   = v.wdata;
        e.dout    = v.exp_dout;
        e.fault   = v.exp_fault;
        e.wcount  = (v.wr && !v.exp_fault) ? 1 : 0;
        e.rcount  = (v.rd && !v.wr && !v.exp_fault) ? WAIT_CYCLES : 0;
        e.fcycles = v.exp_fault ? 1 : WAIT_CYCLES + 1;
        e.latency = v.exp_fault ? 1 : WAIT_CYCLES + 1;
        e.addr    = v.addr;
        e.wdata   = v.wdata;
        e.t_req   = cyc;
        start     = ready_cnt;
        sb_q.push_back(e);
        @(posedge clk); #1;
        MEM_r_en = 1'b1;
        MEM_w_en = 1'b1;
        address  = $urandom;
        data_in  = $urandom;
        @(posedge clk); #1;
        MEM_r_en = 1'b0;
        MEM_w_en = 1'b0;
        address  = '0;
        data_in  = '0;
        n = 0;
        while ((ready_cnt == start) && (n < 40)) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (ready_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=none expected=ready addr=0x%08h", v.addr);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   wp_before;

        for (int i = 0; i < 64; i++) tb_mem[i] = '0;
        rst      = 1'b1;
        MEM_r_en = 1'b0;
        MEM_w_en = 1'b0;
        address  = '0;
        data_in  = '0;

        tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'd1032, 32'h00000005, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'h00000005, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'd1276, 32'hA5A5A5A5, 32'h00000005, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'd1276, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hA5A5A5A5, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'h12345678, 1'b0};
`ifdef MEM_ADDR_CHECK_EN
        tbl[8]  = '{1'b1, 1'b0, 32'd1282, 32'h00000000, 32'h00000000, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'd1020, 32'h0000FFFF, 32'h00000000, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'd1280, 32'h00000000, 32'h00000000, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 32'd1276, 32'h00000000, 32'hA5A5A5A5, 1'b0};
`else
        tbl[8]  = '{1'b1, 1'b0, 32'd1282, 32'h00000000, 32'h12345678, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'd1020, 32'h0000FFFF, 32'h12345678, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'd1280, 32'h00000000, 32'h12345678, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'd1276, 32'h00000000, 32'h0000FFFF, 1'b0};
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_mem_r_en", 32'(mem_r_en), 32'd0);
        chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        rst = 1'b0;
        sb_en = 1'b1;
        @(posedge clk); #1;

        // Table-driven transactions, back to back.
        for (int i = 0; i < 12; i++) do_req(tbl[i]);

        // Reset in the second ACCESS cycle of a write aborts it.
        sb_en = 1'b0;
        wp_before = wpulses;
        MEM_w_en = 1'b1;
        address  = 32'd1040;
        data_in  = 32'hCAFEF00D;
        @(posedge clk); #1;
        MEM_w_en = 1'b0;
        address  = '0;
        data_in  = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_w_en_in_rst", 32'(mem_w_en), 32'd0);
        chk("abort_ready_in_rst", 32'(ready), 32'd0);
        chk("abort_fault_in_rst", 32'(fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_freeze_after", 32'(freeze), 32'd0);
        chk("abort_data_out", data_out, 32'h0);
        chk("abort_mem_address", mem_address, 32'h0);
        repeat (8) @(posedge clk);
        chk("abort_no_w_pulse", 32'(wpulses - wp_before), 32'd0);
        #1;
        sb_en = 1'b1;

        // Next read after the abort completes normally and sees no write.
        v = '{1'b1, 1'b0, 32'd1040, 32'h00000000, 32'h00000000, 1'b0};
        do_req(v);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
